// File: rtl/periph_mem_arbiter_pkg.sv
// Shared types and constants for the peripheral memory read arbiter.
// Optional read timeout is enabled with the PMA_TIMEOUT_EN macro.
package pma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } pma_state_t;

  localparam int PMA_ADDR_W = 27;
  localparam logic [PMA_ADDR_W-1:0] PMA_IDLE_ADDR = {PMA_ADDR_W{1'b1}};

endpackage

// File: rtl/periph_mem_arbiter_if.sv
// Shared memory read port between the arbiter (master) and the memory controller (slave).
// Optional read timeout is enabled with the PMA_TIMEOUT_EN macro.
interface periph_mem_arbiter_if;
  import pma_pkg::*;

  logic                  mem_rd;
  logic [PMA_ADDR_W-1:0] mem_addr;
  logic                  mem_ack;
  logic [7:0]            mem_data;

  modport master (output mem_rd, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_rd, input mem_addr, output mem_ack, output mem_data);

endinterface

// File: rtl/periph_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index strictly after last_grant.
// Optional read timeout is enabled with the PMA_TIMEOUT_EN macro.
module pma_rr_pick #(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic [NREQ-1:0] pending,
  input  logic [GW-1:0]   last_grant,
  output logic [GW-1:0]   grant,
  output logic            found
);

  // Walk the cyclic order backwards so the nearest candidate is written last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_grant) + k) % NREQ;
      if (pending[idx]) begin
        grant = GW'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_mem_arbiter.sv
// Round-robin arbiter sharing one memory read port among NREQ ROM peripherals.
// Optional read timeout is enabled with the PMA_TIMEOUT_EN macro.
module periph_mem_arbiter
  import pma_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_cs,
  input  logic [PMA_ADDR_W-1:0] req_addr [NREQ],
  output logic [7:0]            req_data,
  output logic [NREQ-1:0]       req_valid,
  output logic                  wait_n,
  periph_mem_arbiter_if.master  mem,
  output logic                  err
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("periph_mem_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  pma_state_t            state;
  pma_state_t            state_next;
  logic [NREQ-1:0]       cs_q;
  logic [NREQ-1:0]       pending;
  logic [NREQ-1:0]       rise;
  logic [NREQ-1:0]       grant_clr;
  logic [PMA_ADDR_W-1:0] addr_l [NREQ];
  logic [PMA_ADDR_W-1:0] iss_addr;
  logic [GW-1:0]         grant_q;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         pick_idx;
  logic                  pick_found;
  logic                  do_grant;
  logic                  timeout_hit;

  assign rise     = req_cs & ~cs_q;
  assign do_grant = (state == IDLE) && pick_found;

  pma_rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .pending    (pending),
    .last_grant (last_grant),
    .grant      (pick_idx),
    .found      (pick_found)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_clr  = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next          = REQ;
          grant_clr[pick_idx] = 1'b1;
        end
      end
      REQ: begin
        if (mem.mem_ack || timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A fresh edge re-arms pending even on the cycle its previous request is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q       <= '0;
      pending    <= '0;
      grant_q    <= '0;
      last_grant <= GW'(NREQ - 1);
      iss_addr   <= PMA_IDLE_ADDR;
      req_data   <= 8'hFF;
      for (int i = 0; i < NREQ; i++) addr_l[i] <= '0;
    end else begin
      cs_q    <= req_cs;
      pending <= (pending & ~grant_clr) | rise;
      for (int i = 0; i < NREQ; i++) begin
        if (rise[i]) addr_l[i] <= req_addr[i];
      end
      if (do_grant) begin
        grant_q  <= pick_idx;
        iss_addr <= addr_l[pick_idx];
      end
      if (state == REQ && mem.mem_ack) begin
        req_data   <= mem.mem_data;
        last_grant <= grant_q;
      end else if (state == REQ && timeout_hit) begin
        req_data   <= 8'hFF;
        last_grant <= grant_q;
      end
    end
  end

  assign mem.mem_rd   = (state == REQ);
  assign mem.mem_addr = (state == REQ) ? iss_addr : PMA_IDLE_ADDR;
  assign req_valid    = (state == DONE) ? (NREQ'(1) << grant_q) : '0;
  assign wait_n       = ~((|rise) | (|pending) | (state != IDLE));

`ifdef PMA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] to_cnt;
  logic          err_q;

  // The abort fires on the REQ cycle that would bring the count up to TIMEOUT.
  assign timeout_hit = (state == REQ) && !mem.mem_ack && (to_cnt == CW'(TIMEOUT - 1));
  assign err         = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (do_grant)            to_cnt <= '0;
      else if (state == REQ)   to_cnt <= to_cnt + CW'(1);
      if (timeout_hit)         err_q  <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_periph_mem_arbiter.sv
// Scoreboard bench for periph_mem_arbiter: directed requests, a memory responder and a completion monitor.
// Define PMA_TIMEOUT_EN to also exercise the read timeout.
module tb_periph_mem_arbiter;
  import pma_pkg::*;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  typedef struct {
    logic [PMA_ADDR_W-1:0] addr;
    int                    delay;
    logic [7:0]            data;
  } mem_t;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [7:0]      data;
  } cmp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_cs;
  logic [PMA_ADDR_W-1:0] req_addr [NREQ];
  logic [7:0]            req_data;
  logic [NREQ-1:0]       req_valid;
  logic                  wait_n;
  logic                  err;
  logic                  resp_ack;
  logic                  late_ack;
  logic [7:0]            resp_data;
  logic [7:0]            late_data;
  bit                    resp_en = 1'b1;
  bit                    mon_en  = 1'b0;

  mem_t mem_q[$];
  cmp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  periph_mem_arbiter_if bus();

  assign bus.mem_ack  = resp_ack | late_ack;
  assign bus.mem_data = late_ack ? late_data : resp_data;

  always #5 clk = ~clk;

  periph_mem_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_cs    (req_cs),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_valid (req_valid),
    .wait_n    (wait_n),
    .mem       (bus.master),
    .err       (err)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int i, input logic [PMA_ADDR_W-1:0] addr, input int hold);
    @(posedge clk); #1;
    req_cs[i]   = 1'b1;
    req_addr[i] = addr;
    repeat (hold) @(posedge clk);
    #1 req_cs[i] = 1'b0;
  endtask

  task automatic wait_mem_rd();
    int k = 0;
    @(negedge clk);
    while (!bus.mem_rd && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_output("mem_rd_seen", 32'(bus.mem_rd), 1);
  endtask

  task automatic drain();
    int k = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || mem_q.size() != 0 || !wait_n) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_output("drain_exp_q", 32'(exp_q.size()), 0);
    check_output("drain_wait_n", 32'(wait_n), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Memory model: acknowledges each read after its scripted delay.
  initial begin
    mem_t e;
    resp_ack  = 1'b0;
    resp_data = 8'h00;
    forever begin
      @(negedge clk);
      if (resp_en && bus.mem_rd) begin
        if (mem_q.size() == 0) begin
          check_output("unexpected_read", 32'(mem_q.size()), 1);
        end else begin
          e = mem_q.pop_front();
          check_output("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
          repeat (e.delay) @(negedge clk);
          check_output("mem_addr_held", 32'(bus.mem_addr), 32'(e.addr));
          resp_ack  = 1'b1;
          resp_data = e.data;
          @(negedge clk);
          resp_ack = 1'b0;
          check_output("mem_rd_drop", 32'(bus.mem_rd), 0);
        end
      end
    end
  end

  // Completion monitor: every req_valid strobe must match the next scoreboard entry.
  initial begin
    cmp_t c;
    forever begin
      @(negedge clk);
      if (mon_en && req_valid !== '0) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_valid", 32'(exp_q.size()), 1);
        end else begin
          c = exp_q.pop_front();
          check_output("req_valid", 32'(req_valid), 32'(c.valid));
          check_output("req_data", 32'(req_data), 32'(c.data));
          check_output("wait_n_done", 32'(wait_n), 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    req_cs   = '0;
    late_ack = 1'b0;
    late_data = 8'h00;
    for (int i = 0; i < NREQ; i++) req_addr[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check_output("rst_mem_rd", 32'(bus.mem_rd), 0);
    check_output("rst_mem_addr", 32'(bus.mem_addr), 32'(PMA_IDLE_ADDR));
    check_output("rst_req_data", 32'(req_data), 32'h00FF);
    check_output("rst_req_valid", 32'(req_valid), 0);
    check_output("rst_err", 32'(err), 0);
    check_output("rst_wait_n", 32'(wait_n), 1);
    mon_en = 1'b1;

    // Single request from requester 1.
    mem_q.push_back('{27'h0020040, 3, 8'h5A});
    exp_q.push_back('{4'b0010, 8'h5A});
    @(posedge clk); #1;
    req_cs[1]   = 1'b1;
    req_addr[1] = 27'h0020040;
    #1 check_output("wait_n_edge", 32'(wait_n), 0);
    @(posedge clk); #1 req_cs[1] = 1'b0;
    drain();
    check_output("req_data_held", 32'(req_data), 32'h5A);

    // Held chip select yields a single transaction; leaves last_grant at 3.
    mem_q.push_back('{27'h1234567, 1, 8'h3C});
    exp_q.push_back('{4'b1000, 8'h3C});
    apply_stimulus(3, 27'h1234567, 10);
    drain();

    // Simultaneous requests 0 and 2, twice.
    for (int r = 0; r < 2; r++) begin
      mem_q.push_back('{27'h0000100 + 27'(r), r, 8'hA0 + 8'(r)});
      mem_q.push_back('{27'h0000300 + 27'(r), 2, 8'hB0 + 8'(r)});
      exp_q.push_back('{4'b0001, 8'hA0 + 8'(r)});
      exp_q.push_back('{4'b0100, 8'hB0 + 8'(r)});
      @(posedge clk); #1;
      req_cs[0]   = 1'b1;
      req_addr[0] = 27'h0000100 + 27'(r);
      req_cs[2]   = 1'b1;
      req_addr[2] = 27'h0000300 + 27'(r);
      @(posedge clk); #1 req_cs = '0;
      drain();
    end

    // Re-request from requester 0 while its first read is in REQ.
    mem_q.push_back('{27'h00ABC00, 4, 8'h11});
    mem_q.push_back('{27'h00ABD00, 0, 8'h22});
    exp_q.push_back('{4'b0001, 8'h11});
    exp_q.push_back('{4'b0001, 8'h22});
    apply_stimulus(0, 27'h00ABC00, 1);
    wait_mem_rd();
    apply_stimulus(0, 27'h00ABD00, 1);
    drain();
    check_output("rereq_data", 32'(req_data), 32'h22);

    // Reset while in REQ, followed by a late acknowledge.
    resp_en = 1'b0;
    apply_stimulus(2, 27'h7000000, 1);
    wait_mem_rd();
    check_output("rst_req_addr", 32'(bus.mem_addr), 32'h7000000);
    do_reset();
    late_data = 8'h77;
    late_ack  = 1'b1;
    @(posedge clk); #1 late_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_mid_mem_rd", 32'(bus.mem_rd), 0);
    check_output("rst_mid_valid", 32'(req_valid), 0);
    check_output("rst_mid_data", 32'(req_data), 32'h00FF);
    check_output("rst_mid_wait_n", 32'(wait_n), 1);
    resp_en = 1'b1;

`ifdef PMA_TIMEOUT_EN
    // No acknowledge: the read aborts after TO cycles in REQ.
    begin
      int n = 0;
      resp_en = 1'b0;
      exp_q.push_back('{4'b0010, 8'hFF});
      apply_stimulus(1, 27'h0000123, 1);
      wait_mem_rd();
      while (bus.mem_rd && n < 50) begin
        n++;
        @(negedge clk);
      end
      check_output("timeout_cycles", 32'(n), 32'(TO));
      drain();
      check_output("err_set", 32'(err), 1);
      repeat (5) @(negedge clk);
      check_output("err_sticky", 32'(err), 1);
      do_reset();
      @(negedge clk);
      check_output("err_cleared", 32'(err), 0);
      resp_en = 1'b1;
    end
`else
    check_output("err_tied", 32'(err), 0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
